// File: rtl/cook_pkg.sv
// Shared types and constants for the cook controller front panel.
package cook_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned STATE_W    = 3;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    // Panel sequencer states; codes 6 and 7 are never entered.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_COOK  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // MM:SS entry, [0]=first_sec, [1]=second_sec, [2]=first_min, [3]=second_min.
    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] entry_t;

    localparam entry_t ENTRY_ZERO = '0;

    // True when a keypad code is a usable BCD digit.
    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
        return (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/entry_shift_reg.sv
// Four-digit MM:SS entry register: clear, capture of live time, or left shift.
module entry_shift_reg
    import cook_pkg::*;
(
    input  logic               clk_1s,
    input  logic               reset,
    input  logic               clr,
    input  logic               capture_en,
    input  entry_t             cap_digits,
    input  logic               shift_en,
    input  logic [DIGIT_W-1:0] digit,
    output entry_t             digits
);

    entry_t r_digits;

    // Clear beats capture beats shift; the oldest digit falls off the top.
    always_ff @(posedge clk_1s) begin
        if (reset || clr) begin
            r_digits <= ENTRY_ZERO;
        end else if (capture_en) begin
            r_digits <= cap_digits;
        end else if (shift_en) begin
            r_digits <= {r_digits[NUM_DIGITS-2:0], digit};
        end
    end

    assign digits = r_digits;

endmodule

// File: rtl/cook_controller.sv
// Front-panel sequencer: keypad entry, timer load/clear, heater and beeper control.
module cook_controller
    import cook_pkg::*;
#(
    parameter int unsigned BEEP_CYCLES = 3
) (
    input  logic               clk_1s,
    input  logic               reset,
    input  logic               key_digit_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               key_start,
    input  logic               key_stop,
    input  logic               door_open,
    input  logic [DIGIT_W-1:0] cur_first_s,
    input  logic [DIGIT_W-1:0] cur_second_s,
    input  logic [DIGIT_W-1:0] cur_first_m,
    input  logic [DIGIT_W-1:0] cur_second_m,
    output logic [DIGIT_W-1:0] entry_first_sec,
    output logic [DIGIT_W-1:0] entry_second_sec,
    output logic [DIGIT_W-1:0] entry_first_min,
    output logic [DIGIT_W-1:0] entry_second_min,
    output logic               load_time_en,
    output logic               clear_input,
    output logic               magnetron_on,
    output logic               beep,
    output logic [STATE_W-1:0] state_out
);

    localparam int unsigned       CNT_W    = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BEEP_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_beep_cnt;
    logic [CNT_W-1:0] w_beep_cnt_next;

    logic   w_shift_en;
    logic   w_capture_en;
    logic   w_clr;
    logic   w_digit_ok;
    logic   w_entry_nz;
    logic   w_cur_zero;
    entry_t w_entry;
    entry_t w_cur;

    assign w_cur      = {cur_second_m, cur_first_m, cur_second_s, cur_first_s};
    assign w_cur_zero = (w_cur == ENTRY_ZERO);
    assign w_entry_nz = (w_entry != ENTRY_ZERO);
    assign w_digit_ok = key_digit_valid && digit_ok(key_digit);

    // Entry digit storage.
    entry_shift_reg u_entry (
        .clk_1s     (clk_1s),
        .reset      (reset),
        .clr        (w_clr),
        .capture_en (w_capture_en),
        .cap_digits (w_cur),
        .shift_en   (w_shift_en),
        .digit      (key_digit),
        .digits     (w_entry)
    );

    // State and beep counter registers.
    always_ff @(posedge clk_1s) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_beep_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_beep_cnt <= w_beep_cnt_next;
        end
    end

    // Next state and entry-register controls; stop > door > start > digit.
    always_comb begin
        w_next          = r_state;
        w_beep_cnt_next = r_beep_cnt;
        w_shift_en      = 1'b0;
        w_capture_en    = 1'b0;
        w_clr           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_digit_ok) begin
                    w_shift_en = 1'b1;
                    w_next     = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (key_stop) begin
                    w_clr  = 1'b1;
                    w_next = ST_IDLE;
                end else if (key_start && !door_open && w_entry_nz) begin
                    w_next = ST_LOAD;
                end else if (w_digit_ok) begin
                    w_shift_en = 1'b1;
                end
            end
            ST_LOAD: begin
                w_next = ST_COOK;
            end
            ST_COOK: begin
                if (key_stop || door_open) begin
                    // Remember the remaining time so a restart can reload it.
                    w_capture_en = 1'b1;
                    w_next       = ST_PAUSE;
                end else if (w_cur_zero) begin
                    w_clr           = 1'b1;
                    w_beep_cnt_next = CNT_LOAD;
                    w_next          = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (key_stop) begin
                    w_clr  = 1'b1;
                    w_next = ST_IDLE;
                end else if (key_start && !door_open) begin
                    w_next = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (key_stop || (r_beep_cnt == '0)) begin
                    w_next = ST_IDLE;
                end else begin
                    w_beep_cnt_next = r_beep_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output decode; the heater gate follows the door with no clock delay.
    assign entry_first_sec  = w_entry[0];
    assign entry_second_sec = w_entry[1];
    assign entry_first_min  = w_entry[2];
    assign entry_second_min = w_entry[3];
    assign load_time_en     = (r_state == ST_LOAD);
    assign clear_input      = !((r_state == ST_LOAD) || (r_state == ST_COOK));
    assign magnetron_on     = (r_state == ST_COOK) && !door_open;
    assign beep             = (r_state == ST_DONE);
    assign state_out        = STATE_W'(r_state);

endmodule
